// File: rtl/led_scan_sequencer.sv
// Scan controller for a single-chain HUB75-style LED panel: fetches bit planes from a frame
// buffer, shifts each row out column by column and unblanks every plane for a weighted time.
module led_scan_sequencer #(
    parameter int unsigned COLS    = 32,
    parameter int unsigned PLANES  = 2,
    parameter int unsigned BASE_ON = 64,
    localparam int unsigned ColW   = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [2:0]      rowmax_in,
    output logic            pix_req,
    output logic [2:0]      pix_row,
    output logic [ColW-1:0] pix_col,
    output logic [1:0]      pix_plane,
    input  logic [2:0]      pix_rgb,
    output logic            red_out,
    output logic            green_out,
    output logic            blue_out,
    output logic            sclk_out,
    output logic            latch_out,
    output logic            blank_out,
    output logic            aclk_out,
    output logic            arst_out,
    output logic            frame_done
);

    localparam int unsigned MaxOn     = BASE_ON << (PLANES - 1);
    localparam int unsigned TimerW    = (MaxOn > 1) ? $clog2(MaxOn) : 1;
    localparam logic [ColW-1:0] LastCol   = ColW'(COLS - 1);
    localparam logic [1:0]      LastPlane = 2'(PLANES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArst,
        StShift,
        StLatch,
        StDisplay,
        StAdvance
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [1:0]        plane_q, plane_d;
    logic [1:0]        phase_q, phase_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              wrap_d;

    logic              pix_req_q, pix_req_d;
    logic [2:0]        pix_row_q, pix_row_d;
    logic [ColW-1:0]   pix_col_q, pix_col_d;
    logic [1:0]        pix_plane_q, pix_plane_d;
    logic [2:0]        rgb_q, rgb_d;
    logic              sclk_q, sclk_d;
    logic              latch_q, latch_d;
    logic              blank_q, blank_d;
    logic              aclk_q, aclk_d;
    logic              arst_q, arst_d;
    logic              done_q, done_d;

    // Sequencing: each column is four phases (request, data return, present, clock high).
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        plane_d = plane_q;
        phase_d = phase_q;
        timer_d = timer_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArst;
            end
            StArst: begin
                state_d = StShift;
                row_d   = '0;
                col_d   = '0;
                plane_d = '0;
                phase_d = '0;
            end
            StShift: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (col_q == LastCol) begin
                        col_d   = '0;
                        state_d = StLatch;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StLatch: begin
                state_d = StDisplay;
                timer_d = TimerW'((BASE_ON << plane_q) - 1);
            end
            StDisplay: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TimerW'(1);
                end else if (plane_q != LastPlane) begin
                    plane_d = plane_q + 2'd1;
                    col_d   = '0;
                    phase_d = '0;
                    state_d = StShift;
                end else begin
                    state_d = StAdvance;
                    // Row limit is sampled as ADVANCE begins so its pulse can be registered.
                    wrap_d  = (row_q >= rowmax_in);
                end
            end
            StAdvance: begin
                plane_d = '0;
                col_d   = '0;
                phase_d = '0;
                if (done_q) begin
                    row_d   = '0;
                    state_d = enable ? StShift : StIdle;
                end else begin
                    row_d   = row_q + 3'd1;
                    state_d = StShift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        pix_req_d = (state_d == StShift) && (phase_d == 2'd0);
        sclk_d    = (state_d == StShift) && (phase_d == 2'd3);
        latch_d   = (state_d == StLatch);
        blank_d   = (state_d != StDisplay);
        aclk_d    = (state_d == StAdvance) && !wrap_d;
        arst_d    = (state_d == StArst) || ((state_d == StAdvance) && wrap_d);
        done_d    = (state_d == StAdvance) && wrap_d;

        pix_row_d   = pix_row_q;
        pix_col_d   = pix_col_q;
        pix_plane_d = pix_plane_q;
        if (pix_req_d) begin
            pix_row_d   = row_d;
            pix_col_d   = col_d;
            pix_plane_d = plane_d;
        end else if (state_d == StIdle) begin
            pix_row_d   = '0;
            pix_col_d   = '0;
            pix_plane_d = '0;
        end

        rgb_d = rgb_q;
        if ((state_q == StShift) && (phase_q == 2'd1)) begin
            rgb_d = pix_rgb;
        end else if (state_d == StIdle) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            plane_q     <= '0;
            phase_q     <= '0;
            timer_q     <= '0;
            pix_req_q   <= 1'b0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            pix_plane_q <= '0;
            rgb_q       <= '0;
            sclk_q      <= 1'b0;
            latch_q     <= 1'b0;
            blank_q     <= 1'b1;
            aclk_q      <= 1'b0;
            arst_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            plane_q     <= plane_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            pix_req_q   <= pix_req_d;
            pix_row_q   <= pix_row_d;
            pix_col_q   <= pix_col_d;
            pix_plane_q <= pix_plane_d;
            rgb_q       <= rgb_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
            blank_q     <= blank_d;
            aclk_q      <= aclk_d;
            arst_q      <= arst_d;
            done_q      <= done_d;
        end
    end

    assign pix_req    = pix_req_q;
    assign pix_row    = pix_row_q;
    assign pix_col    = pix_col_q;
    assign pix_plane  = pix_plane_q;
    assign red_out    = rgb_q[2];
    assign green_out  = rgb_q[1];
    assign blue_out   = rgb_q[0];
    assign sclk_out   = sclk_q;
    assign latch_out  = latch_q;
    assign blank_out  = blank_q;
    assign aclk_out   = aclk_q;
    assign arst_out   = arst_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer: two configurations checked every cycle against a timeline
// model (row/cycle arithmetic), plus literal timing expectations and randomized control.
module tb_led_scan_sequencer;

    localparam int C0 = 32, P0 = 2, B0 = 64;
    localparam int C1 = 2,  P1 = 1, B1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, en0, rst1_n, en1;
    logic [2:0] rmax0, rmax1, rgb0, rgb1;

    logic       req0, r0, g0, b0, sclk0, latch0, blank0, aclk0, arst0, done0;
    logic [2:0] row0;
    logic [4:0] col0;
    logic [1:0] pl0;
    logic       req1, r1, g1, b1, sclk1, latch1, blank1, aclk1, arst1, done1;
    logic [2:0] row1;
    logic [0:0] col1;
    logic [1:0] pl1;

    led_scan_sequencer #(.COLS(C0), .PLANES(P0), .BASE_ON(B0)) dut0 (
        .clk(clk), .reset_n(rst0_n), .enable(en0), .rowmax_in(rmax0),
        .pix_req(req0), .pix_row(row0), .pix_col(col0), .pix_plane(pl0), .pix_rgb(rgb0),
        .red_out(r0), .green_out(g0), .blue_out(b0), .sclk_out(sclk0), .latch_out(latch0),
        .blank_out(blank0), .aclk_out(aclk0), .arst_out(arst0), .frame_done(done0)
    );

    led_scan_sequencer #(.COLS(C1), .PLANES(P1), .BASE_ON(B1)) dut1 (
        .clk(clk), .reset_n(rst1_n), .enable(en1), .rowmax_in(rmax1),
        .pix_req(req1), .pix_row(row1), .pix_col(col1), .pix_plane(pl1), .pix_rgb(rgb1),
        .red_out(r1), .green_out(g1), .blue_out(b1), .sclk_out(sclk1), .latch_out(latch1),
        .blank_out(blank1), .aclk_out(aclk1), .arst_out(arst1), .frame_done(done1)
    );

    // Packed view: req,row[3],col[8],plane[2],rgb[3],sclk,latch,blank,aclk,arst,done
    logic [22:0] act0, act1;
    assign act0 = {req0, row0, 3'b0, col0, pl0, r0, g0, b0, sclk0, latch0, blank0, aclk0, arst0,
                   done0};
    assign act1 = {req1, row1, 7'b0, col1, pl1, r1, g1, b1, sclk1, latch1, blank1, aclk1, arst1,
                   done1};

    // Frame buffer: one-cycle latency; garbage when not requested.
    logic [2:0] fb [2][8][32][4];
    always @(posedge clk) rgb0 <= req0 ? fb[0][row0][col0][pl0] : 3'($urandom);
    always @(posedge clk) rgb1 <= req1 ? fb[1][row1][col1][pl1] : 3'($urandom);

    int n_cmp = 0, n_fail = 0;
    bit chk_on = 1'b0, tb1_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cols_of(input int i);   return (i == 0) ? C0 : C1; endfunction
    function automatic int planes_of(input int i); return (i == 0) ? P0 : P1; endfunction
    function automatic int base_of(input int i);   return (i == 0) ? B0 : B1; endfunction
    function automatic int ptime(input int i, input int p);
        return 4 * cols_of(i) + 1 + (base_of(i) << p);
    endfunction
    function automatic int rowtime(input int i);
        int s = 1;
        for (int p = 0; p < planes_of(i); p++) s += ptime(i, p);
        return s;
    endfunction
    function automatic logic rst_of(input int i);  return (i == 0) ? rst0_n : rst1_n; endfunction
    function automatic logic en_of(input int i);   return (i == 0) ? en0 : en1; endfunction
    function automatic int rmax_of(input int i);   return (i == 0) ? int'(rmax0) : int'(rmax1);
    endfunction

    // Model: mode 0 idle, 1 arst, 2 running at cycle m_t of row m_row.
    int m_mode [2], m_row [2], m_t [2];
    bit m_wrap [2];
    initial for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_row[i] = 0; m_t[i] = 0; m_wrap[i] = 1'b0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_of(i)) begin
                m_mode[i] = 0; m_row[i] = 0; m_t[i] = 0; m_wrap[i] = 1'b0;
            end else if (m_mode[i] == 0) begin
                if (en_of(i)) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                m_mode[i] = 2; m_row[i] = 0; m_t[i] = 0;
            end else if (m_t[i] == rowtime(i) - 1) begin
                if (m_wrap[i]) begin
                    m_row[i]  = 0;
                    m_mode[i] = en_of(i) ? 2 : 0;
                end else begin
                    m_row[i]++;
                end
                m_t[i] = 0;
            end else begin
                m_t[i]++;
                if (m_t[i] == rowtime(i) - 1) m_wrap[i] = (m_row[i] >= rmax_of(i));
            end
        end
    end

    task automatic exp_out(input int i, output logic [22:0] e, output logic [22:0] m);
        int t, p, col, ph;
        e = '0;
        m = '1;
        if (!rst_of(i) || m_mode[i] == 0) begin
            e[3] = 1'b1;
        end else if (m_mode[i] == 1) begin
            e[3] = 1'b1;
            e[1] = 1'b1;
        end else begin
            m[21:6] = '0;
            t = m_t[i];
            if (t == rowtime(i) - 1) begin
                e[3] = 1'b1;
                e[2] = !m_wrap[i];
                e[1] = m_wrap[i];
                e[0] = m_wrap[i];
            end else begin
                p = 0;
                while (t >= ptime(i, p)) begin
                    t -= ptime(i, p);
                    p++;
                end
                if (t < 4 * cols_of(i)) begin
                    col  = t / 4;
                    ph   = t % 4;
                    e[3] = 1'b1;
                    if (ph == 0) begin
                        e[22]    = 1'b1;
                        e[21:19] = 3'(m_row[i]);
                        e[18:11] = 8'(col);
                        e[10:9]  = 2'(p);
                        m[21:9]  = '1;
                    end
                    if (ph >= 2) begin
                        e[8:6] = fb[i][m_row[i]][col][p];
                        m[8:6] = '1;
                    end
                    e[5] = (ph == 3);
                end else if (t == 4 * cols_of(i)) begin
                    e[4] = 1'b1;
                    e[3] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] e, m, a;
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                exp_out(i, e, m);
                a = (i == 0) ? act0 : act1;
                n_cmp++;
                if ((a & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL model[%0d] t=%0t row=%0d cyc=%0d: got %h, expected %h mask %h",
                             i, $time, m_row[i], m_t[i], a, e, m);
                end
            end
        end
    end

    // Instance 0: default configuration.
    initial begin
        int cyc, ns, nb, na, nd, nq, run0, found;
        bit run_done;
        rst0_n = 1'b0; en0 = 1'b0; rmax0 = 3'd1;
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 32; c++)
                    for (int p = 0; p < 4; p++) fb[i][r][c][p] = 3'($urandom);
        @(negedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        check("reset_blank", int'(blank0), 1);
        check("reset_outputs", int'(act0), 8);
        rst0_n = 1'b1;
        repeat (3) @(negedge clk);
        en0 = 1'b1;
        @(negedge clk);
        check("first_arst", int'(arst0), 1);

        cyc = 0; ns = 0; nb = 0; na = 0; run0 = 0; run_done = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            ns += int'(sclk0);
            nb += int'(!blank0);
            na += int'(aclk0);
            if (!blank0 && !run_done) run0++;
            if (blank0 && run0 > 0) run_done = 1'b1;
        end while (!done0 && cyc < 5000);
        check("frame_len", cyc, 902);
        check("sclk_pulses", ns, 128);
        check("blank_low_total", nb, 384);
        check("plane0_window", run0, 64);
        check("aclk_pulses", na, 1);
        check("wrap_arst", int'(arst0), 1);

        repeat (10) @(negedge clk);
        en0 = 1'b0;
        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            @(negedge clk);
            if (done0) found = 1;
        end
        check("stop_frame_done", found, 1);
        ns = 0; nq = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ns += int'(sclk0);
            nq += int'(req0) + int'(!blank0);
        end
        check("idle_quiet", ns + nq, 0);
        en0 = 1'b1;
        @(negedge clk);
        check("rearm_arst", int'(arst0), 1);

        rmax0 = 3'd0;
        na = 0; nd = 0;
        for (int k = 0; k < 1400; k++) begin
            @(negedge clk);
            na += int'(aclk0);
            nd += int'(done0 & arst0);
        end
        check("rmax0_aclk", na, 0);
        check("rmax0_wraps", nd, 3);

        rmax0 = 3'd7;
        found = 0;
        for (int k = 0; k < 6000 && found == 0; k++) begin
            @(negedge clk);
            if (m_row[0] == 5) found = 1;
        end
        check("reach_row5", found, 1);
        rmax0 = 3'd2;
        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            @(negedge clk);
            if (aclk0 || arst0) found = 1;
        end
        check("lowered_wrap", int'(arst0 & done0 & !aclk0) + found, 2);

        for (int k = 0; k < 25000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) rmax0 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) en0 = ($urandom_range(0, 99) < 70);
        end

        en0 = 1'b1;
        found = 0;
        for (int k = 0; k < 5000 && found == 0; k++) begin
            @(negedge clk);
            if (!blank0) found = 1;
        end
        check("reach_display", found, 1);
        #2 rst0_n = 1'b0;
        #1 check("async_reset", int'(act0), 8);
        repeat (3) @(negedge clk);
        en0 = 1'b0;
        rst0_n = 1'b1;
        ns = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ns += int'(sclk0) + int'(!blank0);
        end
        check("post_reset_quiet", ns, 0);

        found = 0;
        for (int k = 0; k < 30000 && found == 0; k++) begin
            @(negedge clk);
            if (tb1_done) found = 1;
        end
        check("cfg1_finished", found, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Instance 1: COLS=2, PLANES=1, BASE_ON=1.
    initial begin
        int cyc, nb, nl, found;
        rst1_n = 1'b0; en1 = 1'b0; rmax1 = 3'd0;
        repeat (4) @(negedge clk);
        rst1_n = 1'b1;
        en1 = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (aclk1 || arst1) found = 1;
        end
        check("cfg1_first_adv", found, 1);
        cyc = 0; nb = 0; nl = 0; found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            cyc++;
            nb += int'(!blank1);
            nl += int'(latch1 & (aclk1 | arst1));
            if (aclk1 || arst1) found = 1;
        end
        check("cfg1_row_time", cyc, 11);
        check("cfg1_blank_low", nb, 1);
        check("cfg1_pulse_overlap", nl, 0);
        rmax1 = 3'd3;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) rmax1 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) en1 = ($urandom_range(0, 99) < 75);
        end
        tb1_done = 1'b1;
    end

endmodule

// File: doc/led_scan_sequencer.md
# led_scan_sequencer

Scan controller for the single-chain HUB75-style LED panel. It walks rows `0..rowmax_in` and, per row, shifts `COLS` pixels for each binary-code-modulation bit plane, latches them and unblanks for a plane-weighted time. It drives the panel pins (`red/green/blue`, `sclk`, `latch`, `blank`, and the shift-register row driver `aclk`/`arst`). Pixel bits are fetched from a frame buffer with one-cycle read latency. It sits between the frame buffer and the board-level pin wrapper.

## Interface
Parameters:
- `COLS`, 32, pixels per row; power of two, ≥2.
- `PLANES`, 2, bit planes per row; 1..4.
- `BASE_ON`, 64, unblanked clk cycles for plane 0; plane p is unblanked `BASE_ON<<p` cycles; ≥1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; sampled in IDLE and at frame wrap.
- `rowmax_in`  in  3  index of the last panel row (0..7).
- `pix_req`  out  1  frame-buffer read strobe.
- `pix_row`  out  3  read row address.
- `pix_col`  out  clog2(COLS)  read column address.
- `pix_plane`  out  2  read bit-plane address.
- `pix_rgb`  in  3  {r,g,b} read data; valid the cycle after `pix_req`.
- `red_out`, `green_out`, `blue_out`  out  1 each  panel serial data.
- `sclk_out`  out  1  panel shift clock.
- `latch_out`  out  1  panel latch strobe.
- `blank_out`  out  1  panel blank/OE; 1 = dark.
- `aclk_out`  out  1  row driver advance pulse.
- `arst_out`  out  1  row driver reset-to-row-0 pulse.
- `frame_done`  out  1  one-cycle pulse at frame wrap.

## Operation
- All outputs are registered.
- States: IDLE, ARST, SHIFT, LATCH, DISPLAY, ADVANCE.
- Reset (asynchronous, immediate):
  - state IDLE; row, col, plane and timer counters 0.
  - `blank_out`=1; every other output 0.
- IDLE:
  - Outputs hold reset values.
  - `enable`=1 → ARST.
- ARST (1 cycle):
  - `arst_out`=1 to resynchronise the physical row driver.
  - Row=0, plane=0 → SHIFT.
  - `frame_done` stays 0.
- SHIFT: each column c = 0..COLS-1 takes 4 cycles:
  - P0: `pix_req`=1, addresses = {row, c, plane}, `sclk_out`=0.
  - P1: `pix_rgb` captured at the end of the cycle.
  - P2: rgb outputs = captured data, `sclk_out`=0.
  - P3: `sclk_out`=1, rgb held.
  - After c = COLS-1, P3 → LATCH.
- LATCH (1 cycle): `latch_out`=1, `sclk_out`=0 → DISPLAY.
- DISPLAY:
  - `blank_out`=0 for exactly `BASE_ON<<plane` cycles.
  - Then, if plane < PLANES-1: plane+1 → SHIFT.
  - Otherwise → ADVANCE.
- ADVANCE (1 cycle):
  - If row ≥ `rowmax_in`: `arst_out`=1, `frame_done`=1, row=0, plane=0. Then `enable`=1 → SHIFT, `enable`=0 → IDLE.
  - Otherwise: `aclk_out`=1, row+1, plane=0 → SHIFT.
- `blank_out`=1 in every state except DISPLAY.
- `pix_req`=0 outside SHIFT P0.
- `latch`, `aclk`, `arst` pulses never overlap each other or DISPLAY.
- `rowmax_in` is used only in ADVANCE and may change at any time. The comparison is `≥`, so lowering it below the current row wraps at the next ADVANCE.
- `enable`=0 mid-frame has no effect until the wrap; the frame always completes.
- Timer width covers `BASE_ON<<(PLANES-1)` with no overflow. Column and row counters wrap only via the FSM, never by natural overflow.

## Timing
- `enable` rising in IDLE → ARST next cycle → first `pix_req` the cycle after.
- `pix_req` at cycle k → data on the rgb outputs in cycle k+2 → `sclk_out` rising edge starts cycle k+3. Data is stable ≥1 cycle before and through the sclk high cycle.
- Plane p time = 4·COLS + 1 + (BASE_ON<<p) cycles.
- Row time = Σ plane times + 1.
- Defaults:
  - Plane 0 = 193 cycles, plane 1 = 257 cycles, row = 451 cycles.
  - Frame with `rowmax_in`=7: 3608 cycles, plus 1 ARST cycle from IDLE.

## Test plan
- Reset: drive `reset_n`=0 mid-DISPLAY → same cycle `blank_out`=1, all other outputs 0, no `sclk_out` edges until `enable` with reset released.
- Defaults, `rowmax_in`=1: `enable`=1 → ARST pulse, 32 sclk pulses, latch, blank low 64 cycles, 32 sclk, latch, blank low 128 cycles, `aclk_out` pulse. Row 1 repeats the plane sequence, then `arst_out` + `frame_done` together, 902 cycles after ARST.
- Data path: frame-buffer model returns `pix_rgb`={col[0], col[1], plane}; check each sclk rising edge samples the matching rgb for every col/plane, with `pix_row` correct.
- `rowmax_in`=0: every ADVANCE issues `arst_out` and `frame_done`, never `aclk_out`. Change `rowmax_in` from 7→2 while row=5 → wrap at that row's ADVANCE.
- Stop: drop `enable` during row 0 → frame completes, `frame_done` pulses, then IDLE with `blank_out`=1. Re-raise → ARST is again the first action.
- `PLANES`=1, `BASE_ON`=1, `COLS`=2: row time = 11 cycles. Check the blank-low window is exactly 1 cycle and `latch_out`/`aclk_out` never coincide.
